// File: rtl/inst_fetch_if.sv
// Fetch-side bus bundle: the ROM address/data pair and the valid/ready
// output register that feeds the decoder.
//   master : fetch unit (drives InstAddress, Inst, InstPc, InstValid)
//   slave  : ROM + decoder side (drives InstIn, InstReady)
// Handshake: Inst/InstPc are meaningful while InstValid=1; a transfer happens
// on a rising edge where InstValid=1 and InstReady=1; while InstValid=1 and
// InstReady=0 the producer holds Inst/InstPc stable; InstReady with
// InstValid=0 has no effect.
interface inst_fetch_if #(
    parameter int ADDR_W = 7,
    parameter int INST_W = 9
);
    logic [ADDR_W-1:0] InstAddress;
    logic [INST_W-1:0] InstIn;
    logic [INST_W-1:0] Inst;
    logic [ADDR_W-1:0] InstPc;
    logic              InstValid;
    logic              InstReady;

    modport master (
        output InstAddress,
        output Inst,
        output InstPc,
        output InstValid,
        input  InstIn,
        input  InstReady
    );

    modport slave (
        input  InstAddress,
        input  Inst,
        input  InstPc,
        input  InstValid,
        output InstIn,
        output InstReady
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, addresses the combinational ROM and
// hands each fetched word to the decoder through a one-entry valid/ready
// register. Supports Start, Halt and branch redirect.
// Optional build macro INST_FETCH_WRAP_HALT_EN: a capture from the last ROM
// address halts the unit instead of wrapping the PC to 0.
// DbgState exposes the FSM state (0=IDLE, 1=RUN, 2=HALTED).
module inst_fetch #(
    parameter int                ADDR_W     = 7,
    parameter int                INST_W     = 9,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Halt,
    input  logic              BranchEn,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic              Done,
    output logic [1:0]        DbgState,
    inst_fetch_if.master      bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

`ifdef INST_FETCH_WRAP_HALT_EN
    localparam logic [ADDR_W-1:0] PC_MAX = '1;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] inst_nxt;
    logic [ADDR_W-1:0] inst_pc;
    logic [ADDR_W-1:0] inst_pc_nxt;
    logic              inst_valid;
    logic              inst_valid_nxt;
    logic              slot_free;
    logic              transfer;

    // The output slot can take a new word if it is empty or draining now.
    assign transfer  = inst_valid && bus.InstReady;
    assign slot_free = !inst_valid || bus.InstReady;

    // Next-state, PC and output-register control, priority Branch > Halt > fetch.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        inst_valid_nxt = inst_valid;

        unique case (state)
            IDLE: begin
                // The Start edge only loads the PC; fetching begins next edge.
                if (Start) begin
                    pc_nxt    = START_ADDR;
                    state_nxt = RUN;
                end
            end

            RUN: begin
                if (BranchEn) begin
                    // Redirect flushes the held word even if it was being accepted.
                    pc_nxt         = BranchTarget;
                    inst_valid_nxt = 1'b0;
                    if (Halt) begin
                        state_nxt = HALTED;
                    end
                end else if (Halt) begin
                    // Stop fetching; a held word stays until the decoder takes it.
                    state_nxt = HALTED;
                    if (transfer) begin
                        inst_valid_nxt = 1'b0;
                    end
                end else if (slot_free) begin
                    inst_nxt       = bus.InstIn;
                    inst_pc_nxt    = pc;
                    inst_valid_nxt = 1'b1;
`ifdef INST_FETCH_WRAP_HALT_EN
                    // Last ROM word: deliver it, then park instead of wrapping.
                    if (pc == PC_MAX) begin
                        state_nxt = HALTED;
                    end else begin
                        pc_nxt = pc + ADDR_W'(1);
                    end
`else
                    pc_nxt = pc + ADDR_W'(1);
`endif
                end
                // Otherwise stall: slot full and not accepted, hold everything.
            end

            HALTED: begin
                if (Start) begin
                    // Restart drops whatever was still waiting for the decoder.
                    pc_nxt         = START_ADDR;
                    state_nxt      = RUN;
                    inst_valid_nxt = 1'b0;
                end else if (transfer) begin
                    inst_valid_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt      = IDLE;
                inst_valid_nxt = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Program counter register.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            pc <= START_ADDR;
        end else begin
            pc <= pc_nxt;
        end
    end

    // One-entry output register toward the decoder.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
            inst_valid <= inst_valid_nxt;
        end
    end

    assign bus.InstAddress = pc;
    assign bus.Inst        = inst;
    assign bus.InstPc      = inst_pc;
    assign bus.InstValid   = inst_valid;
    assign Done            = (state == HALTED) && !inst_valid;
    assign DbgState        = state;

    // A word waiting for the decoder must not change under it.
    held_word_stable: assert property (
        @(posedge CLK) disable iff (!Reset_n)
        (inst_valid && !bus.InstReady) |=> ($stable(inst) && $stable(inst_pc))
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: ROM model, scoreboard of expected
// {InstPc, Inst} transfers, one task per scenario.
module tb_inst_fetch;

    localparam int              ADDR_W     = 7;
    localparam int              INST_W     = 9;
    localparam logic [ADDR_W-1:0] START_ADDR = '0;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic              CLK;
    logic              Reset_n;
    logic              Start;
    logic              Halt;
    logic              BranchEn;
    logic [ADDR_W-1:0] BranchTarget;
    logic              Done;
    logic [1:0]        DbgState;

    logic [INST_W-1:0] rom [0:(1<<ADDR_W)-1];
    logic [ADDR_W+INST_W-1:0] exp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    inst_fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    inst_fetch #(
        .ADDR_W    (ADDR_W),
        .INST_W    (INST_W),
        .START_ADDR(START_ADDR)
    ) dut (
        .CLK         (CLK),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .Halt        (Halt),
        .BranchEn    (BranchEn),
        .BranchTarget(BranchTarget),
        .Done        (Done),
        .DbgState    (DbgState),
        .bus         (bus)
    );

    // ---------------- clock / reset / ROM ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign bus.InstIn = rom[bus.InstAddress];

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [ADDR_W+INST_W-1:0] entry(input int pc);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(pc);
        return {a, rom[a]};
    endfunction

    task automatic clear_inputs();
        Start        = 1'b0;
        Halt         = 1'b0;
        BranchEn     = 1'b0;
        BranchTarget = '0;
    endtask

    // ---------------- scoreboard ----------------
    // Inputs only change just after a rising edge, so sampling on the falling
    // edge sees exactly what the next rising edge will act on.
    always @(negedge CLK) begin
        if (Reset_n && bus.InstValid && bus.InstReady) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: got pc=%0d inst=%h, none expected",
                         bus.InstPc, bus.Inst);
            end else begin
                logic [ADDR_W+INST_W-1:0] e;
                e = exp_q.pop_front();
                if ({bus.InstPc, bus.Inst} !== e) begin
                    tests_failed++;
                    $display("FAIL sb_transfer: got pc=%0d inst=%h, want pc=%0d inst=%h",
                             bus.InstPc, bus.Inst, e[ADDR_W+INST_W-1:INST_W], e[INST_W-1:0]);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset_n = 1'b0;
        clear_inputs();
        bus.InstReady = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({bus.InstValid, Done, bus.Inst, bus.InstPc} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%0b done=%0b inst=%h pc=%0d, want all 0",
                     bus.InstValid, Done, bus.Inst, bus.InstPc);
        end
        tests_run++;
        if (bus.InstAddress !== START_ADDR || DbgState !== S_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got addr=%0d state=%0d, want addr=%0d state=0",
                     bus.InstAddress, DbgState, START_ADDR);
        end
        Reset_n       = 1'b1;
        bus.InstReady = 1'b1;
        tick();
        tick();
        tests_run++;
        if (bus.InstValid !== 1'b0 || DbgState !== S_IDLE) begin
            tests_failed++;
            $display("FAIL idle_no_fetch: got valid=%0b state=%0d, want 0/0",
                     bus.InstValid, DbgState);
        end
    endtask

    task automatic test_stream_backpressure_halt();
        for (int i = 0; i < 4; i++) exp_q.push_back(entry(i));
        bus.InstReady = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tests_run++;
        if (bus.InstValid !== 1'b0 || bus.InstAddress !== START_ADDR || DbgState !== S_RUN) begin
            tests_failed++;
            $display("FAIL start_edge: got valid=%0b addr=%0d state=%0d, want 0/%0d/1",
                     bus.InstValid, bus.InstAddress, DbgState, START_ADDR);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if (bus.InstValid !== 1'b1 || bus.Inst !== 9'(i + 1) || bus.InstPc !== 7'(i)) begin
                tests_failed++;
                $display("FAIL stream_%0d: got valid=%0b inst=%h pc=%0d, want 1/%h/%0d",
                         i, bus.InstValid, bus.Inst, bus.InstPc, 9'(i + 1), i);
            end
        end
        bus.InstReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (bus.InstValid !== 1'b1 || bus.Inst !== 9'h002 || bus.InstPc !== 7'd1 ||
                bus.InstAddress !== 7'd2) begin
                tests_failed++;
                $display("FAIL stall_%0d: got valid=%0b inst=%h pc=%0d addr=%0d, want 1/002/1/2",
                         i, bus.InstValid, bus.Inst, bus.InstPc, bus.InstAddress);
            end
        end
        bus.InstReady = 1'b1;
        for (int i = 2; i < 4; i++) begin
            tick();
            tests_run++;
            if (bus.InstValid !== 1'b1 || bus.Inst !== 9'(i + 1) || bus.InstPc !== 7'(i)) begin
                tests_failed++;
                $display("FAIL resume_%0d: got valid=%0b inst=%h pc=%0d, want 1/%h/%0d",
                         i, bus.InstValid, bus.Inst, bus.InstPc, 9'(i + 1), i);
            end
        end
        // Halt while the last word is held and not accepted.
        bus.InstReady = 1'b0;
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        tick();
        tests_run++;
        if (DbgState !== S_HALTED || Done !== 1'b0 || bus.InstValid !== 1'b1 ||
            bus.Inst !== 9'h004 || bus.InstAddress !== 7'd4) begin
            tests_failed++;
            $display("FAIL halt_held: got state=%0d done=%0b valid=%0b inst=%h addr=%0d, want 2/0/1/004/4",
                     DbgState, Done, bus.InstValid, bus.Inst, bus.InstAddress);
        end
        bus.InstReady = 1'b1;
        tick();
        tests_run++;
        if (bus.InstValid !== 1'b0 || Done !== 1'b1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL halt_drain: got valid=%0b done=%0b pending=%0d, want 0/1/0",
                     bus.InstValid, Done, exp_q.size());
        end
        bus.InstReady = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tests_run++;
        if (bus.InstAddress !== START_ADDR || Done !== 1'b0 || DbgState !== S_RUN) begin
            tests_failed++;
            $display("FAIL restart: got addr=%0d done=%0b state=%0d, want %0d/0/1",
                     bus.InstAddress, Done, DbgState, START_ADDR);
        end
    endtask

    task automatic test_branch();
        // RUN, PC=0, slot empty, decoder not ready: word 0 is captured then flushed.
        bus.InstReady = 1'b0;
        tick();
        BranchEn = 1'b1;
        BranchTarget = 7'd40;
        tick();
        BranchEn = 1'b0;
        tests_run++;
        if (bus.InstValid !== 1'b0 || bus.InstAddress !== 7'd40) begin
            tests_failed++;
            $display("FAIL branch_flush: got valid=%0b addr=%0d, want 0/40",
                     bus.InstValid, bus.InstAddress);
        end
        exp_q.push_back(entry(40));
        exp_q.push_back(entry(41));
        bus.InstReady = 1'b1;
        tick();
        tests_run++;
        if (bus.InstValid !== 1'b1 || bus.Inst !== rom[40] || bus.InstPc !== 7'd40) begin
            tests_failed++;
            $display("FAIL branch_target: got valid=%0b inst=%h pc=%0d, want 1/%h/40",
                     bus.InstValid, bus.Inst, bus.InstPc, rom[40]);
        end
        tick();
        // Branch and Halt together: redirect wins, then the unit parks.
        BranchEn = 1'b1;
        BranchTarget = 7'd126;
        Halt = 1'b1;
        tick();
        tests_run++;
        if (bus.InstValid !== 1'b0 || bus.InstAddress !== 7'd126 || DbgState !== S_HALTED ||
            Done !== 1'b1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL branch_halt: got valid=%0b addr=%0d state=%0d done=%0b pending=%0d, want 0/126/2/1/0",
                     bus.InstValid, bus.InstAddress, DbgState, Done, exp_q.size());
        end
        // Branch/Halt are ignored once halted.
        BranchTarget = 7'd5;
        tick();
        clear_inputs();
        tests_run++;
        if (bus.InstAddress !== 7'd126 || DbgState !== S_HALTED) begin
            tests_failed++;
            $display("FAIL halted_ignore: got addr=%0d state=%0d, want 126/2",
                     bus.InstAddress, DbgState);
        end
    endtask

    task automatic test_wrap();
        bus.InstReady = 1'b1;
        Start = 1'b1;
        tick();
        // Start held high in RUN must not disturb the redirect.
        BranchEn = 1'b1;
        BranchTarget = 7'd126;
        tick();
        clear_inputs();
        tests_run++;
        if (bus.InstAddress !== 7'd126 || bus.InstValid !== 1'b0 || DbgState !== S_RUN) begin
            tests_failed++;
            $display("FAIL wrap_setup: got addr=%0d valid=%0b state=%0d, want 126/0/1",
                     bus.InstAddress, bus.InstValid, DbgState);
        end
        exp_q.push_back(entry(126));
        exp_q.push_back(entry(127));
`ifndef INST_FETCH_WRAP_HALT_EN
        exp_q.push_back(entry(0));
        exp_q.push_back(entry(1));
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (bus.InstValid !== 1'b1 || bus.InstPc !== 7'(126 + i)) begin
                tests_failed++;
                $display("FAIL wrap_seq_%0d: got valid=%0b pc=%0d, want 1/%0d",
                         i, bus.InstValid, bus.InstPc, 7'(126 + i));
            end
        end
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
`else
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if (bus.InstValid !== 1'b1 || bus.InstPc !== 7'(126 + i)) begin
                tests_failed++;
                $display("FAIL wrap_seq_%0d: got valid=%0b pc=%0d, want 1/%0d",
                         i, bus.InstValid, bus.InstPc, 7'(126 + i));
            end
        end
        tick();
`endif
        tests_run++;
        if (Done !== 1'b1 || bus.InstValid !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL wrap_end: got done=%0b valid=%0b pending=%0d, want 1/0/0",
                     Done, bus.InstValid, exp_q.size());
        end
`ifdef INST_FETCH_WRAP_HALT_EN
        tests_run++;
        if (bus.InstAddress !== 7'd127) begin
            tests_failed++;
            $display("FAIL wrap_park: got addr=%0d, want 127", bus.InstAddress);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int budget;
        for (int i = 0; i <= 20; i++) exp_q.push_back(entry(i));
        bus.InstReady = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        budget = 400;
        while (exp_q.size() > 1 && budget > 0) begin
            bus.InstReady = 1'($urandom_range(0, 1));
            tick();
            budget--;
        end
        tests_run++;
        if (budget == 0) begin
            tests_failed++;
            $display("FAIL b2b_timeout: got pending=%0d, want 1", exp_q.size());
        end
        bus.InstReady = 1'b0;
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        bus.InstReady = 1'b1;
        tick();
        tests_run++;
        if (exp_q.size() != 0 || Done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_drain: got pending=%0d done=%0b, want 0/1", exp_q.size(), Done);
            exp_q.delete();
        end
    endtask

    task automatic test_async_reset();
        bus.InstReady = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        tests_run++;
        if (bus.InstValid !== 1'b0 || bus.InstAddress !== START_ADDR || DbgState !== S_IDLE ||
            bus.Inst !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got valid=%0b addr=%0d state=%0d inst=%h, want 0/%0d/0/000",
                     bus.InstValid, bus.InstAddress, DbgState, bus.Inst, START_ADDR);
        end
        tick();
        Reset_n = 1'b1;
        bus.InstReady = 1'b1;
        BranchEn = 1'b1;
        BranchTarget = 7'd50;
        Halt = 1'b1;
        tick();
        tick();
        clear_inputs();
        tests_run++;
        if (bus.InstValid !== 1'b0 || bus.InstAddress !== START_ADDR || DbgState !== S_IDLE) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got valid=%0b addr=%0d state=%0d, want 0/%0d/0",
                     bus.InstValid, bus.InstAddress, DbgState, START_ADDR);
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            rom[i] = (i < 4) ? 9'(i + 1) : 9'($urandom_range(0, 511));
        end
        test_reset();
        test_stream_backpressure_halt();
        test_branch();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: got pending=%0d, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, want finish", $time);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch unit on the requesting side of the instruction ROM interface.
- Holds the program counter (PC) and drives InstAddress. Captures the ROM's combinational 9-bit word and presents it to the decoder through a one-entry valid/ready output register.
- Supports start, halt and branch redirect. Sits between the instruction ROM and the decode stage of the lab processor.

Parameters:
- ADDR_W, 7, PC / InstAddress width (128-entry ROM).
- INST_W, 9, instruction word width.
- START_ADDR, 0, PC value loaded on Start.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Start  input  1  begin fetching from START_ADDR; honoured only in IDLE or HALTED.
- Halt  input  1  stop fetching after current cycle; honoured in RUN.
- BranchEn  input  1  redirect PC; honoured in RUN.
- BranchTarget  input  ADDR_W  redirect address.
- InstAddress  output  ADDR_W  address to ROM; always equals PC.
- InstIn  input  INST_W  combinational ROM data for InstAddress.
- Inst  output  INST_W  registered instruction to decoder.
- InstPc  output  ADDR_W  address Inst was fetched from.
- InstValid  output  1  Inst/InstPc valid.
- InstReady  input  1  decoder accepts Inst this cycle.
- Done  output  1  HALTED and output register empty.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE, PC=START_ADDR, Inst=0, InstPc=0, InstValid=0, Done=0.
  - Reset mid-run discards any held instruction immediately.
- States: IDLE, RUN, HALTED.
- IDLE:
  - Start=1 -> PC<=START_ADDR, state<=RUN.
  - No fetch happens on the Start edge; the first fetch is on the next edge.
- RUN, evaluated each edge in priority order:
  1. BranchEn=1:
     - PC<=BranchTarget, InstValid<=0 (flush, even if InstReady=0). No capture this edge.
     - If Halt=1 in the same cycle, state<=HALTED after the redirect.
  2. Halt=1: state<=HALTED, no capture. The held instruction (if any) remains until InstReady.
  3. Slot free (InstValid=0 or InstReady=1): Inst<=InstIn, InstPc<=PC, InstValid<=1, PC<=PC+1.
  4. Otherwise (InstValid=1, InstReady=0): stall. PC, Inst, InstPc unchanged.
- Handshake:
  - A transfer occurs on an edge with InstValid=1 and InstReady=1.
  - Inst/InstPc stay stable while InstValid=1 and InstReady=0.
  - Sustained throughput is one instruction per cycle.
- Latency: PC value N appears on Inst/InstValid one edge after PC=N with the slot free.
- PC arithmetic is modulo 2^ADDR_W: 127+1 -> 0 (wrap) unless the optional feature below is enabled.
- HALTED:
  - No fetch. InstValid clears on the next transfer.
  - Done = (state==HALTED) && !InstValid, combinational.
  - Start=1 -> PC<=START_ADDR, state<=RUN, InstValid<=0 (held instruction dropped).
- Ignored inputs:
  - Start in RUN is ignored.
  - BranchEn/Halt in IDLE or HALTED are ignored.
- InstReady while InstValid=0 has no effect.

Optional Feature:
- Macro: INST_FETCH_WRAP_HALT_EN.
- Defined:
  - A capture from PC=2^ADDR_W-1 also sets state<=HALTED and leaves PC at 2^ADDR_W-1 (no wrap).
  - The captured word is still delivered normally.
- Undefined: PC wraps to 0 and fetching continues.

Test Plan:
- Reset then Start, InstReady=1, ROM[0..3]=9'h001,9'h002,9'h003,9'h004 -> Inst=001,002,003,004 on consecutive cycles, InstPc=0..3, InstValid stays 1 from the 2nd edge after Start.
- Backpressure: InstReady=0 for 3 cycles while Inst=9'h002 -> Inst, InstPc=1 and InstAddress=2 held. InstReady=1 -> next Inst=9'h003.
- Branch: BranchEn=1, BranchTarget=7'd40 while InstValid=1 -> InstValid=0 next cycle, InstAddress=40. Following edge Inst=ROM[40], InstPc=40.
- Halt with InstReady=0, InstValid=1 -> no further fetch, Done=0. Raise InstReady -> InstValid=0, Done=1. Start -> InstAddress=START_ADDR, Done=0.
- Wrap: BranchTarget=126, InstReady=1 -> InstPc sequence 126,127,0,1 (macro undefined). With INST_FETCH_WRAP_HALT_EN: sequence 126,127, then Done=1, InstAddress=127.
- Async reset asserted mid-run between edges -> InstValid=0, InstAddress=START_ADDR immediately. After release, no fetch until Start.
